// File: rtl/rt_access_ctrl.sv
// Access controller for a racetrack-memory line: aligns the shared access
// ports by unidirectional master/slave shifting, then reads or writes one word.
module rt_access_ctrl #(
  parameter int NR = 4,
  parameter int NB = 32,
  parameter int NP = 8
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          req_i,
  output logic          gnt_o,
  input  logic [$clog2(NB)-1:0] addr_i,
  input  logic          we_i,
  input  logic [1:0]    target_i,
  input  logic [NR-1:0] wdata_i,
  output logic          rvalid_o,
  output logic [NR-1:0] rdata_o,
  output logic [NB-1:0] word_lines_o,
  output logic          current_m_data_o,
  output logic          current_m_mask_o,
  output logic          current_m_program_o,
  output logic          current_m_lim_o,
  output logic          current_s_data_o,
  output logic          current_s_mask_o,
  output logic          current_s_program_o,
  output logic          current_s_lim_o,
  output logic          Bz_m_o,
  output logic          Bz_s_o,
  output logic          read_current_d_o,
  output logic          read_current_m_o,
  output logic          read_current_p_o,
  output logic [NR-1:0] write_i_data_o,
  output logic [NR-1:0] write_i_mask_o,
  output logic [NR-1:0] write_i_program_o,
  output logic          write_en_data_o,
  output logic          write_en_mask_o,
  output logic          write_en_program_o,
  output logic          out_select_o,
  input  logic [NR-1:0] r_data_i,
  input  logic [NR-1:0] r_data_m_i,
  input  logic [NR-1:0] r_data_p_i
);
  localparam int NSP = NB / NP;
  localparam int AW  = $clog2(NB);
  localparam int PW  = (NSP > 1) ? $clog2(NSP) : 1;

  localparam logic [1:0] T_DATA = 2'd0;
  localparam logic [1:0] T_MASK = 2'd1;
  localparam logic [1:0] T_PROG = 2'd2;
  localparam logic [1:0] T_LIM  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT_M = 3'd1,
    S_SHIFT_S = 3'd2,
    S_ACCESS  = 3'd3,
    S_RESP    = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [1:0]    tgt_q, tgt_d;
  logic [NR-1:0] wdata_q, wdata_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [NR-1:0] rdata_q, rdata_d;
  logic [PW-1:0] steps_s;

  // NSP is a power of two, so the PW-bit subtraction is the modulo distance.
  assign steps_s = addr_i[PW-1:0] - pos_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      tgt_q   <= 2'd0;
      wdata_q <= '0;
      pos_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      tgt_q   <= tgt_d;
      wdata_q <= wdata_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    tgt_d   = tgt_q;
    wdata_d = wdata_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          addr_d  = addr_i;
          we_d    = we_i;
          tgt_d   = target_i;
          wdata_d = wdata_i;
          cnt_d   = steps_s;
          state_d = (steps_s == '0) ? S_ACCESS : S_SHIFT_M;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT_M: state_d = S_SHIFT_S;
      S_SHIFT_S: begin
        cnt_d   = cnt_q - 1'b1;
        pos_d   = pos_q + 1'b1;
        state_d = (cnt_q == {{(PW-1){1'b0}}, 1'b1}) ? S_ACCESS : S_SHIFT_M;
      end
      S_ACCESS: begin
        if (!we_q) begin
          case (tgt_q)
            T_MASK:  rdata_d = r_data_m_i;
            T_PROG:  rdata_d = r_data_p_i;
            default: rdata_d = r_data_i;
          endcase
        end else if (tgt_q == T_LIM) begin
          rdata_d = '0;
        end else begin
          rdata_d = rdata_q;
        end
        state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_o               = (state_q == S_IDLE) & req_i & rstn_i;
    rvalid_o            = (state_q == S_RESP);
    rdata_o             = rdata_q;
    word_lines_o        = '0;
    current_m_data_o    = 1'b0;
    current_m_mask_o    = 1'b0;
    current_m_program_o = 1'b0;
    current_m_lim_o     = 1'b0;
    current_s_data_o    = 1'b0;
    current_s_mask_o    = 1'b0;
    current_s_program_o = 1'b0;
    current_s_lim_o     = 1'b0;
    Bz_m_o              = 1'b0;
    Bz_s_o              = 1'b0;
    read_current_d_o    = 1'b0;
    read_current_m_o    = 1'b0;
    read_current_p_o    = 1'b0;
    write_i_data_o      = '0;
    write_i_mask_o      = '0;
    write_i_program_o   = '0;
    write_en_data_o     = 1'b0;
    write_en_mask_o     = 1'b0;
    write_en_program_o  = 1'b0;
    out_select_o        = 1'b0;
    case (state_q)
      S_SHIFT_M: begin
        current_m_data_o    = 1'b1;
        current_m_mask_o    = 1'b1;
        current_m_program_o = 1'b1;
        current_m_lim_o     = 1'b1;
        Bz_m_o              = (tgt_q == T_LIM);
      end
      S_SHIFT_S: begin
        current_s_data_o    = 1'b1;
        current_s_mask_o    = 1'b1;
        current_s_program_o = 1'b1;
        current_s_lim_o     = 1'b1;
        Bz_s_o              = (tgt_q == T_LIM);
      end
      S_ACCESS: begin
        word_lines_o[addr_q] = 1'b1;
        if (!we_q) begin
          read_current_d_o = (tgt_q == T_DATA) || (tgt_q == T_LIM);
          read_current_m_o = (tgt_q == T_MASK);
          read_current_p_o = (tgt_q == T_PROG);
          out_select_o     = (tgt_q == T_LIM);
        end else begin
          write_en_data_o    = (tgt_q == T_DATA);
          write_en_mask_o    = (tgt_q == T_MASK);
          write_en_program_o = (tgt_q == T_PROG);
          write_i_data_o     = (tgt_q == T_DATA) ? wdata_q : '0;
          write_i_mask_o     = (tgt_q == T_MASK) ? wdata_q : '0;
          write_i_program_o  = (tgt_q == T_PROG) ? wdata_q : '0;
        end
      end
      default: begin
        word_lines_o = '0;
      end
    endcase
  end
endmodule

// File: doc/rt_access_ctrl.md
RT_ACCESS_CTRL -- requirements
Module: rt_access_ctrl

Interface
REQ-001 Parameter NR, default 4: racetracks per line, which is the data width.
REQ-002 Parameter NB, default 32: bits per racetrack, which is the word count.
REQ-003 Parameter NP, default 8: access ports per racetrack; NSP = NB/NP, default 4.
REQ-004 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 rstn_i  in  1  reset; asynchronous, active-low.
REQ-006 req_i  in  1  access request.
REQ-007 gnt_o  out  1  request accepted this cycle.
REQ-008 addr_i  in  log2(NB)  word index.
REQ-009 we_i  in  1  1 = write, 0 = read.
REQ-010 target_i  in  2  selected plane: 0 data, 1 mask, 2 program, 3 lim.
REQ-011 wdata_i  in  NR  write data.
REQ-012 rvalid_o  out  1  one-cycle completion strobe for both reads and writes.
REQ-013 rdata_o  out  NR  read data, valid while rvalid_o is high.
REQ-014 word_lines_o  out  NB  one-hot word select to the array.
REQ-015 current_m_{data,mask,program,lim}_o / current_s_{data,mask,program,lim}_o  out  1 each  master/slave shift currents.
REQ-016 Bz_m_o, Bz_s_o  out  1 each  pNML field strobes.
REQ-017 read_current_{d,m,p}_o  out  1 each  read currents for the data, mask and program planes.
REQ-018 write_i_{data,mask,program}_o  out  NR each  write data per plane.
REQ-019 write_en_{data,mask,program}_o  out  1 each  write enables per plane.
REQ-020 out_select_o  out  1  array output mux select: 1 = lim, 0 = data.
REQ-021 r_data_i, r_data_m_i, r_data_p_i  in  NR each  array read outputs.

Function
REQ-022 FSM states: IDLE, SHIFT_M, SHIFT_S, ACCESS, RESP.
REQ-023 gnt_o SHALL equal req_i while in IDLE and 0 in every other state.
REQ-024 On grant, the block registers addr_i, we_i, target_i and wdata_i. It then computes steps = (addr_i mod NSP − pos) mod NSP, where pos is a log2(NSP)-bit offset register.
REQ-025 Grant transition: steps = 0 → ACCESS; otherwise → SHIFT_M with step counter = steps.
REQ-026 SHIFT_M: all four current_m_* outputs = 1; Bz_m_o = 1 only if target = lim; next state SHIFT_S.
REQ-027 SHIFT_S: all four current_s_* outputs = 1; Bz_s_o = 1 only if target = lim.
REQ-027a SHIFT_S also decrements the step counter and increments pos modulo NSP (wraps from NSP−1 to 0); next state is ACCESS if the counter reaches 0, else SHIFT_M.
REQ-028 Shifting is unidirectional and all planes shift together; each shift step costs exactly 2 cycles.
REQ-029 ACCESS: word_lines_o[addr] = 1 and all other word lines 0. This is the only state in which word_lines_o is nonzero.
REQ-030 ACCESS, read: assert the read current of the target plane (read_current_d_o for data and lim); out_select_o = 1 iff target = lim; rdata_o captures the matching input (r_data_i for data/lim, r_data_m_i, r_data_p_i) at the end of the cycle.
REQ-031 ACCESS, write to data/mask/program: assert the matching write_en_*_o and drive the matching write_i_*_o = wdata.
REQ-032 ACCESS, write with target = lim: no write enables assert; the transaction completes normally with rdata_o = 0.
REQ-033 RESP: rvalid_o = 1 for exactly one cycle; next state IDLE. No new grant is given during RESP.
REQ-034 Latency from grant edge to rvalid_o: 2·steps + 2 cycles, so 2 cycles minimum and 2·(NSP−1) + 2 cycles maximum.
REQ-035 All array-facing outputs not named for the current state SHALL be 0. Write and read signals are never active in the same cycle.
REQ-036 rdata_o holds its value until the next read completes; a write leaves it unchanged, except in the REQ-032 case.
REQ-037 req_i deasserted after grant has no effect on the transaction in flight.

Reset
REQ-038 rstn_i low SHALL asynchronously force state IDLE, pos = 0, step counter = 0, rdata_o = 0 and every output to 0.
REQ-039 Reset asserted mid-transaction aborts it with no rvalid_o. Because the array shares the same reset, pos = 0 stays consistent with it.

Verification
REQ-040 After reset, read with addr = 0, target = data → 0 shift steps; rvalid_o 2 cycles after grant; word_lines_o = 0x00000001 during ACCESS.
REQ-041 From pos = 0, write addr = 7 (offset 3), wdata = 0xA, target = mask → 3 SHIFT_M/SHIFT_S pairs, write_en_mask_o pulse with write_i_mask_o = 0xA, rvalid_o at cycle 8, pos = 3.
REQ-042 With pos = 3, read addr = 1 (offset 1), target = program → steps = 2 (wrap through 0), rvalid_o at cycle 6, rdata_o = r_data_p_i sampled in ACCESS, pos = 1.
REQ-043 Read with target = lim → Bz_m_o/Bz_s_o pulse with each shift phase; out_select_o = 1 and read_current_d_o = 1 in ACCESS.
REQ-044 Hold req_i high continuously → gnt_o only in IDLE cycles; never two grants without an intervening rvalid_o.
REQ-045 Drop rstn_i during SHIFT_S → all outputs 0 immediately; no rvalid_o; next request computes steps from pos = 0.
